// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: register address width,
// parameter defaults and the grant selector used by the port mux.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int DEFAULT_XLEN     = 32;
    localparam int DEFAULT_DEPTH    = 2;
    localparam int DEFAULT_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

    // A buffered long-latency result is packed as {rd, data}.
    function automatic int entry_width(input int xlen);
        return REG_ADDR_W + xlen;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results; the head is visible
// combinationally so it can be popped onto the write port the same cycle.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH = entry_width(DEFAULT_XLEN),
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == PW'(gi))) begin
                    r_mem[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (PW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order writeback and a
// buffered long-latency unit, with a starvation counter forcing FIFO drains.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_rd,
    input  logic [XLEN-1:0]       p_data,
    output logic                  pipe_stall,
    input  logic                  l_valid,
    output logic                  l_ready,
    input  logic [REG_ADDR_W-1:0] l_rd,
    input  logic [XLEN-1:0]       l_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wd,
    output logic [DEPTH:0]        pending
);

    localparam int EW = entry_width(XLEN);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0]         r_wait_cnt;
    logic [EW-1:0]         w_head;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_p_needs;
    logic                  w_force;
    logic                  w_push;
    logic                  w_pop;
    grant_e                w_grant;

    assign w_p_needs   = p_valid && (p_rd != '0);
    assign w_force     = (r_wait_cnt >= WW'(MAX_WAIT)) && !w_fifo_empty;
    assign w_head_rd   = w_head[EW-1 -: REG_ADDR_W];
    assign w_head_data = w_head[XLEN-1:0];

    // Acceptance depends only on registered occupancy, so a full FIFO refuses
    // a push even in a cycle where it is also being popped.
    assign l_ready = !rst && !w_fifo_full;
    assign w_push  = l_valid && l_ready && (l_rd != '0);
    assign w_pop   = (w_grant == GRANT_FIFO);

    always_comb begin
        w_grant    = GRANT_NONE;
        pipe_stall = 1'b0;
        if (!rst) begin
            if (w_force) begin
                w_grant    = GRANT_FIFO;
                pipe_stall = w_p_needs;
            end else if (w_p_needs) begin
                w_grant = GRANT_PIPE;
            end else if (!w_fifo_empty) begin
                w_grant = GRANT_FIFO;
            end
        end
    end

    assign rf_we = (w_grant != GRANT_NONE);
    assign rf_rd = (w_grant == GRANT_FIFO) ? w_head_rd   : p_rd;
    assign rf_wd = (w_grant == GRANT_FIFO) ? w_head_data : p_data;

    // Counts consecutive cycles the buffered head lost the port to the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < WW'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({l_rd, l_data}),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign pending = (DEPTH+1)'(w_fifo_count);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter with a queue-based model.
module tb_wb_port_arbiter;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            p_valid;
    logic [4:0]      p_rd;
    logic [XLEN-1:0] p_data;
    logic            pipe_stall;
    logic            l_valid;
    logic            l_ready;
    logic [4:0]      l_rd;
    logic [XLEN-1:0] l_data;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [DEPTH:0]  pending;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: buffered entries in arrival order plus denied-cycle count.
    logic [36:0] mq[$];
    int          m_wait  = 0;
    bit          started = 0;
    bit          m_stall = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .pipe_stall(pipe_stall),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .pending(pending)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check outputs
    // against the model, then advance the model to the next rising edge.
    task automatic tick(input logic t_rst, input logic t_pv, input logic [4:0] t_prd,
                        input logic [31:0] t_pd, input logic t_lv, input logic [4:0] t_lrd,
                        input logic [31:0] t_ld);
        int  sz;
        bit  e_lr, e_we, e_st, pop, frc, pn;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        @(negedge clk);
        rst = t_rst; p_valid = t_pv; p_rd = t_prd; p_data = t_pd;
        l_valid = t_lv; l_rd = t_lrd; l_data = t_ld;
        #1;
        sz   = mq.size();
        e_lr = !t_rst && (sz < DEPTH);
        e_we = 0; e_st = 0; pop = 0; e_rd = 0; e_wd = 0;
        if (!t_rst) begin
            frc = (m_wait >= MAX_WAIT) && (sz > 0);
            pn  = t_pv && (t_prd != 0);
            if (frc) begin
                e_we = 1; e_st = pn; pop = 1;
                e_rd = mq[0][36:32]; e_wd = mq[0][31:0];
            end else if (pn) begin
                e_we = 1; e_rd = t_prd; e_wd = t_pd;
            end else if (sz > 0) begin
                e_we = 1; pop = 1;
                e_rd = mq[0][36:32]; e_wd = mq[0][31:0];
            end
        end
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_st));
        chk("l_ready", 32'(l_ready), 32'(e_lr));
        if (started) chk("pending", 32'(pending), 32'(sz));
        if (e_we) begin
            chk("rf_rd", 32'(rf_rd), 32'(e_rd));
            chk("rf_wd", rf_wd, e_wd);
        end
        $display("cyc t=%0t rst=%0b p=%0b/%0d l=%0b/%0d -> we=%0b rd=%0d wd=%0h stall=%0b lr=%0b pend=%0d",
                 $time, t_rst, t_pv, t_prd, t_lv, t_lrd, rf_we, rf_rd, rf_wd, pipe_stall, l_ready, pending);
        if (t_rst) begin
            mq.delete();
            m_wait = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (t_lv && e_lr && (t_lrd != 0)) mq.push_back({t_lrd, t_ld});
            if (pop || sz == 0) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
        m_stall = e_st;
        started = 1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic       r_pv, r_lv;
        logic [4:0] r_prd, r_lrd;
        logic [31:0] r_pd, r_ld;

        // Reset with both requesters active.
        tick(1, 1, 5'd7, 32'h1, 1, 5'd9, 32'h2);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_lready", 32'(l_ready), 32'd0);
        tick(1, 1, 5'd7, 32'h1, 1, 5'd9, 32'h2);
        chk("rst_pending", 32'(pending), 32'd0);
        idle();
        chk("post_rst_lready", 32'(l_ready), 32'd1);

        // Idle drain.
        tick(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        idle();
        chk("drain_we", 32'(rf_we), 32'd1);
        chk("drain_rd", 32'(rf_rd), 32'd5);
        chk("drain_wd", rf_wd, 32'hDEADBEEF);
        idle();
        chk("drain_pending", 32'(pending), 32'd0);

        // Pipeline priority until the starvation limit.
        tick(0, 1, 5'd3, 32'h11, 1, 5'd6, 32'h66);
        for (int k = 0; k < MAX_WAIT; k++) begin
            tick(0, 1, 5'd3, 32'h11, 0, 0, 0);
            chk("prio_rd", 32'(rf_rd), 32'd3);
        end
        tick(0, 1, 5'd3, 32'h11, 0, 0, 0);
        chk("force_rd", 32'(rf_rd), 32'd6);
        chk("force_stall", 32'(pipe_stall), 32'd1);
        tick(0, 1, 5'd3, 32'h11, 0, 0, 0);
        chk("after_force_rd", 32'(rf_rd), 32'd3);
        chk("after_force_stall", 32'(pipe_stall), 32'd0);
        idle();

        // x0 handling.
        tick(0, 0, 0, 0, 1, 5'd8, 32'h88);
        tick(0, 1, 5'd0, 32'h77, 0, 0, 0);
        chk("x0_rd", 32'(rf_rd), 32'd8);
        chk("x0_stall", 32'(pipe_stall), 32'd0);
        tick(0, 0, 0, 0, 1, 5'd0, 32'h99);
        chk("x0_lready", 32'(l_ready), 32'd1);
        idle();
        chk("x0_pending", 32'(pending), 32'd0);
        chk("x0_we", 32'(rf_we), 32'd0);

        // Full FIFO with forced pop refusing the push.
        tick(0, 1, 5'd3, 32'h33, 1, 5'd10, 32'hA);
        tick(0, 1, 5'd3, 32'h33, 1, 5'd11, 32'hB);
        tick(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hC);
        chk("full_lready", 32'(l_ready), 32'd0);
        chk("full_pending", 32'(pending), 32'd2);
        tick(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hC);
        tick(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hC);
        tick(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hC);
        chk("fullforce_rd", 32'(rf_rd), 32'd10);
        chk("fullforce_lready", 32'(l_ready), 32'd0);
        chk("fullforce_stall", 32'(pipe_stall), 32'd1);
        tick(0, 1, 5'd3, 32'h33, 0, 0, 0);
        chk("fullforce_pending", 32'(pending), 32'd1);
        for (int k = 0; k < 4; k++) idle();

        // Reset mid-operation discards buffered entries.
        tick(0, 1, 5'd3, 32'h44, 1, 5'd13, 32'hD);
        tick(0, 1, 5'd3, 32'h44, 1, 5'd14, 32'hE);
        tick(1, 1, 5'd3, 32'h44, 0, 0, 0);
        chk("midrst_we", 32'(rf_we), 32'd0);
        idle();
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_we2", 32'(rf_we), 32'd0);
        idle();
        chk("midrst_we3", 32'(rf_we), 32'd0);

        // Randomised traffic; pipeline inputs are held while stalled.
        r_pv = 0; r_prd = 0; r_pd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_stall) begin
                r_pv  = ($urandom_range(0, 99) < 60);
                r_prd = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) r_prd = 0;
                r_pd  = $urandom;
            end
            r_lv  = ($urandom_range(0, 99) < 45);
            r_lrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) r_lrd = 0;
            r_ld  = $urandom;
            tick(($urandom_range(0, 199) == 0), r_pv, r_prd, r_pd, r_lv, r_lrd, r_ld);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
